adder_pipe_nbit: RTL and testbench
==================================

// Module: adder_pipe_nbit
// PURPOSE
//   Parametrised, pipelined N-bit add/subtract unit.
//   Splits operands into SEG-bit segments and resolves one segment's carry per stage.
//   Sustains one operation per clock at high WIDTH.
//   Valid/ready handshake on both sides; sits between an operand producer and a result consumer.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of SEG
//   SEG     4  segment width, i.e. bits resolved per pipeline stage
//   (derived localparam NSEG = WIDTH/SEG = pipeline depth and latency)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      unit accepts operand beat this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: a+b+cin; 1: a-b-cin
//   out_valid  out  1      result beat available
//   out_ready  in   1      consumer accepts result this cycle
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry-out; in sub mode 1 = no borrow
//   ovf        out  1      two's-complement signed overflow of the operation
// BEHAVIOUR
//   - Reset, sampled on the clk edge with rst=1:
//     - out_valid=0, sum=0, cout=0, ovf=0; all stage valid bits cleared.
//     - In-flight operations are discarded; in_ready=1 on the first cycle after reset.
//   - Arithmetic: sub=1 is computed as a + ~b + !cin over WIDTH+1 bits.
//     - cout = bit WIDTH of that sum.
//     - ovf = (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]), with b' = sub ? ~b : b.
//   - Pipeline: NSEG stages, each holding a valid bit. Stage k adds segment k of a and b'
//     with the carry registered by stage k-1. Stage 0 uses the effective carry-in.
//     Lower result segments and upper operand segments travel with the beat.
//   - Global advance enable: adv = !out_valid || out_ready.
//     - in_ready = adv (combinational); transfer-in occurs when in_valid && in_ready.
//     - When adv=0 every stage and the outputs hold; no beat is lost or duplicated.
//     - Bubbles (in_valid=0 while adv=1) propagate as invalid stages.
//   - Latency: a beat accepted at edge t has out_valid=1 after edge t+NSEG if never stalled.
//     Each stalled cycle adds one cycle.
//   - Throughput: 1 beat/cycle while out_ready=1.
//   - sum/cout/ovf are registered and stable while out_valid=1 && out_ready=0.
//     They are don't-care while out_valid=0, but the registers update only on valid beats.
//   - Segment-boundary carries (e.g. 0x0FFF+1) must ripple correctly across stages.
//   - Wrap-around: sum is truncated to WIDTH; the carry appears only on cout.
//   - rst has priority over simultaneous in_valid/out_ready activity.
// TESTING  (WIDTH=16, SEG=4, latency 4)
//   1. a=0x000C b=0x0003 cin=0 sub=0, out_ready=1
//      -> after 4 cycles: sum=0x000F cout=0 ovf=0.
//   2. Cross-segment carry:
//      a=0x0FFF b=0x0001 -> sum=0x1000 cout=0.
//      a=0xFFFF b=0xFFFF cin=1 -> sum=0xFFFF cout=1.
//   3. Sub/overflow:
//      a=0x0005 b=0x0007 sub=1 cin=0 -> sum=0xFFFE cout=0 ovf=0.
//      a=0x7FFF b=0x0001 add -> sum=0x8000 ovf=1.
//   4. Back-to-back: 8 consecutive beats (a=i, b=i), out_ready=1
//      -> 8 results 2*i on 8 consecutive cycles, in order.
//   5. Stall: hold out_ready=0 for 5 cycles with a full pipeline
//      -> in_ready=0, output beat held stable; release -> all beats delivered, none lost.
//   6. Assert rst with 3 beats in flight
//      -> next cycle out_valid=0, sum=0; no stale result ever appears afterwards.

Source files
------------

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
//   Pipelined WIDTH-bit add/subtract unit. Operands are split into SEG-bit
//   segments; each pipeline stage resolves one segment and registers the
//   carry into the next. The unit sustains one operation per clock. It has a
//   valid/ready handshake on both sides.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat offered
//   in_ready   unit accepts an operand beat this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result beat available
//   out_ready  consumer accepts the result this cycle
//   sum        result modulo 2^WIDTH
//   cout       carry-out; in sub mode 1 means no borrow
//   ovf        two's-complement signed overflow
module adder_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  // Stage k holds the operands and the partial result with segments
  // 0..k-1 already resolved. It also holds the carry into segment k.
  logic             vld_p [NSEG];
  logic [WIDTH-1:0] a_p   [NSEG];
  logic [WIDTH-1:0] bb_p  [NSEG];
  logic [WIDTH-1:0] res_p [NSEG];
  logic             cy_p  [NSEG];

  logic [SEG:0]     seg_s   [NSEG];
  logic [WIDTH-1:0] res_nxt [NSEG];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           c);
    seg_add = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  function automatic logic sgn_ovf(input logic sa, input logic sb, input logic ss);
    sgn_ovf = (sa == sb) && (ss != sa);
  endfunction

  // One global enable: the whole pipe moves only when the output slot is free
  // or is being drained this cycle, so no beat is ever dropped or duplicated.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + !cin.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_s[k]   = seg_add(a_p[k][k*SEG +: SEG], bb_p[k][k*SEG +: SEG], cy_p[k]);
      res_nxt[k] = res_p[k];
      res_nxt[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
    end
  end

  // Control path and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) vld_p[k] <= vld_p[k-1];
      out_valid <= vld_p[NSEG-1];
      if (vld_p[NSEG-1]) begin
        sum  <= res_nxt[NSEG-1];
        cout <= seg_s[NSEG-1][SEG];
        ovf  <= sgn_ovf(a_p[NSEG-1][WIDTH-1], bb_p[NSEG-1][WIDTH-1],
                        res_nxt[NSEG-1][WIDTH-1]);
      end
    end
  end

  // Stage 0: capture operands
  // Stages 1..NSEG-1: resolve one segment per hop
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        a_p[0]   <= a;
        bb_p[0]  <= b_eff;
        res_p[0] <= '0;
        cy_p[0]  <= c_eff;
      end
      for (int k = 1; k < NSEG; k++) begin
        if (vld_p[k-1]) begin
          a_p[k]   <= a_p[k-1];
          bb_p[k]  <= bb_p[k-1];
          res_p[k] <= res_nxt[k-1];
          cy_p[k]  <= seg_s[k-1][SEG];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit (WIDTH=16, SEG=4, latency 4).
module tb_adder_pipe_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_op(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic xs,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL %s_in_ready got %b want 1", nm, in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin lat = i; break; end
    end
    total++; if (lat != 4) $display("FAIL %s_latency got %0d want 4", nm, lat); else passed++;
    total++; if (sum !== es) $display("FAIL %s_sum got %h want %h", nm, sum, es); else passed++;
    total++; if (cout !== ec) $display("FAIL %s_cout got %b want %b", nm, cout, ec); else passed++;
    total++; if (ovf !== eo) $display("FAIL %s_ovf got %b want %b", nm, ovf, eo); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL %s_single_beat out_valid got %b want 0", nm, out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1;
    bit acc, take;
    logic [15:0] snap;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (sent < 8); a = 16'(sent); b = 16'(sent); out_ready = 1'b1;
      #1;
      acc = in_valid && in_ready; take = out_valid && out_ready; snap = sum;
      @(posedge clk); #1;
      if (acc) sent++;
      if (take) begin
        if (first < 0) first = cyc;
        total++; if (snap !== 16'(2 * got)) $display("FAIL b2b_sum[%0d] got %h want %h", got, snap, 16'(2 * got)); else passed++;
        total++; if (cyc != first + got) $display("FAIL b2b_cycle[%0d] got %0d want %0d", got, cyc, first + got); else passed++;
        got++;
      end
      if (got == 8) break;
    end
    in_valid = 1'b0;
    total++; if (got != 8) $display("FAIL b2b_count got %0d want 8", got); else passed++;
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, stall_left = 5;
    bit acc, take, stalled_prev = 0;
    logic [15:0] snap, held = '0;
    logic [15:0] exp_q[$];
    logic [15:0] e;
    cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      in_valid = (sent < 10); a = 16'(16'h0100 + sent); b = 16'(sent);
      if (out_valid === 1'b1 && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else passed++;
        if (stalled_prev) begin
          total++; if (sum !== held) $display("FAIL stall_hold_sum got %h want %h", sum, held); else passed++;
        end
        held = sum; stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      acc = in_valid && in_ready; take = out_valid && out_ready; snap = sum;
      @(posedge clk); #1;
      if (acc) begin exp_q.push_back(16'(16'h0100 + 2 * sent)); sent++; end
      if (take) begin
        if (exp_q.size() == 0) begin
          total++; $display("FAIL stall_extra_beat got %h want none", snap);
        end else begin
          e = exp_q.pop_front();
          total++; if (snap !== e) $display("FAIL stall_sum[%0d] got %h want %h", got, snap, e); else passed++;
        end
        got++;
      end
      if (got == 10) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 10) $display("FAIL stall_count got %0d want 10", got); else passed++;
    total++; if (stall_left != 0) $display("FAIL stall_applied left %0d want 0", stall_left); else passed++;
  endtask

  task automatic test_reset_inflight();
    int bad = 0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(16'h1111 * (i + 1)); b = 16'h0001;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; a = 16'h4444;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_inflight_out_valid got %b want 0", out_valid); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL rst_inflight_sum got %h want 0000", sum); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_inflight_in_ready got %b want 1", in_ready); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL rst_inflight_stale got %0d valid cycles want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_op("add_basic",   16'h000C, 16'h0003, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);
    test_op("seg_carry",   16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    test_op("wrap_cin",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    test_op("sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_op("sub_borrow",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    test_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_back_to_back();
    test_stall();
    test_reset_inflight();
    test_op("after_rst",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
